muldiv_unit: RTL
================

# muldiv_unit

Iterative multiply/divide unit with architectural HI/LO registers for the single-cycle datapath. It sits directly downstream of the ALUSrc `mux2`: operand A is `busa` and operand B is the mux `result`. It executes MULT, MULTU, DIV and DIVU over WIDTH+1 cycles behind a start/busy/done handshake, and performs MTHI/MTLO as single-cycle writes. Control stalls the pipeline while `busy` is high and reads `hi`/`lo` for MFHI/MFLO.

## Interface
- WIDTH, 32, operand and result width; the iteration count equals WIDTH.

- clk  in  1  rising-edge clock
- rst_n  in  1  reset; one clock, synchronous, active-low
- start  in  1  operation request; sampled only while idle
- op  in  3  operation code, encoded in the package: MULT=0, MULTU=1, DIV=2, DIVU=3, MTHI=4, MTLO=5; codes 6 and 7 are no-ops
- a  in  WIDTH  operand A (`busa`; multiplicand or dividend; MTHI/MTLO source)
- b  in  WIDTH  operand B (ALUSrc mux result; multiplier or divisor)
- busy  out  1  high while an operation is in flight
- done  out  1  one-cycle pulse when `hi`/`lo` have just been updated by MULT/DIV
- hi  out  WIDTH  HI register (product high half, or remainder)
- lo  out  WIDTH  LO register (product low half, or quotient)

## Operation
- States: IDLE, CALC, FIX.
- IDLE, start=1, op in 0..3:
  - latch the operand magnitudes; for signed ops also latch the sign flags;
  - clear the accumulator and the counter;
  - move to CALC.
- IDLE, start=1, op=4 (MTHI): `hi`<=`a` at this edge; stay IDLE; no busy, no done.
- IDLE, start=1, op=5 (MTLO): `lo`<=`a` at this edge; stay IDLE; no busy, no done.
- IDLE, start=1, op 6 or 7: ignored.
- CALC, multiply: one shift-add step per cycle on a 2·WIDTH accumulator.
- CALC, divide: one restoring subtract-shift step per cycle.
- CALC exit: the counter reaches WIDTH-1, then the state moves to FIX.
- FIX:
  - apply sign correction;
  - write `hi`/`lo`;
  - pulse `done`;
  - return to IDLE.
- Arithmetic rules:
  - MULT and MULTU produce the full 2·WIDTH-bit product, split as {hi, lo}.
  - Signed division truncates toward zero; the remainder takes the sign of the dividend.
  - Divide by zero (signed or unsigned): lo = all ones, hi = a. No exception is raised.
  - Signed overflow (DIV of 0x80000000 by 0xFFFFFFFF): lo = 0x80000000, hi = 0.
- `start` while busy is ignored; no queueing. The latched operands are unaffected by input changes during CALC.
- `hi`/`lo` hold their previous values during CALC. They change only in FIX, or on an MTHI/MTLO edge.
- Reset value of every output and register is 0: `busy`, `done`, `hi`, `lo`, state=IDLE, counter.
- `rst_n` low on any edge, including mid-CALC or in FIX:
  - abort the operation;
  - clear everything to the reset values;
  - suppress `done` and the HI/LO write.

## Timing
- Start accepted at edge E0. `busy` is high from after E0 through the cycle before E(WIDTH+1).
- CALC occupies WIDTH cycles (edges E1..E(WIDTH)). FIX is active in the cycle before edge E(WIDTH+1).
- At edge E(WIDTH+1), `hi`/`lo` are written and `busy` falls. `done` is high for exactly the following cycle.
- Latency from start to valid `hi`/`lo` is WIDTH+1 edges (33 at default). Back-to-back: a new start may be sampled on the cycle in which `done`=1.
- MTHI/MTLO latency is one edge. The new value is readable the cycle after the start edge.
- `busy` and `done` are registered outputs, not combinational from `start`.

## Structure
- Package `muldiv_pkg` holds:
  - the op encodings (MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO);
  - the state encoding (S_IDLE, S_CALC, S_FIX);
  - the default width constant.
- Sub-module `div_step`: combinational restoring-division step (partial remainder, divisor in; next remainder and quotient bit out). It is instantiated once in `muldiv_unit`. The multiply step stays inline.

## Test plan
- Unsigned multiply: MULTU a=0xFFFFFFFF, b=0xFFFFFFFF.
  - Expect hi=0xFFFFFFFE, lo=0x00000001.
  - `done` high exactly 33 edges after start; `busy` high for 33 cycles.
- Signed multiply: MULT a=0xFFFFFFFD (-3), b=5 → hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- Signed divide and corner cases:
  - DIV a=0xFFFFFFF9 (-7), b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - DIV a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0.
- Unsigned divide by zero: DIVU a=7, b=0 → lo=0xFFFFFFFF, hi=0x00000007; `done` pulses normally.
- Handshake and MTHI:
  - MTHI a=0x12345678 with no start pending → hi=0x12345678 one edge later; `busy` stays 0.
  - Start DIVU 100/7 while a MULT is in flight (issued 5 cycles in) → ignored; `hi`/`lo` end with the MULT result.
- Reset mid-operation: start MULTU 3×4, drive `rst_n` low at cycle 10 for one edge.
  - Expect `busy`, `done`, `hi`, `lo` all 0 and no `done` pulse afterwards.
  - A fresh MULTU 3×4 then completes with lo=12, hi=0.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit: op codes, FSM states
// and the default datapath width.
package muldiv_pkg;

   localparam int MD_WIDTH = 32;

   typedef enum logic [2:0] {
      MD_MULT  = 3'd0,
      MD_MULTU = 3'd1,
      MD_DIV   = 3'd2,
      MD_DIVU  = 3'd3,
      MD_MTHI  = 3'd4,
      MD_MTLO  = 3'd5
   } md_op_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_FIX  = 2'd2
   } md_state_e;

endpackage

// File: rtl/muldiv_unit_div_step.sv
// One combinational restoring-division step: compare the shifted partial
// remainder against the divisor and subtract when it fits.
module div_step
   import muldiv_pkg::*;
#(
   parameter int WIDTH = MD_WIDTH
) (
   input  logic [WIDTH:0]   partial_i,
   input  logic [WIDTH-1:0] divisor_i,
   output logic [WIDTH-1:0] rem_o,
   output logic             q_bit_o
);

   logic [WIDTH:0] diff;

   // partial_i < 2*divisor, so the top bit of diff is a clean borrow flag
   assign diff    = partial_i - {1'b0, divisor_i};
   assign q_bit_o = ~diff[WIDTH];
   assign rem_o   = q_bit_o ? diff[WIDTH-1:0] : partial_i[WIDTH-1:0];

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers; sign-magnitude core,
// one step per cycle, sign correction and HI/LO write in a final FIX cycle.
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int WIDTH = MD_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = $clog2(WIDTH);

   md_state_e          state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic               is_div_q, is_div_d;
   logic               sa_q, sa_d, sb_q, sb_d;
   logic [WIDTH-1:0]   ma_q, ma_d, mb_q, mb_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
   logic               busy_q, busy_d, done_q, done_d;

   logic               signed_op;
   logic [WIDTH-1:0]   abs_a, abs_b;
   logic [WIDTH:0]     mul_sum;
   logic [WIDTH:0]     div_partial;
   logic [WIDTH-1:0]   div_rem;
   logic               div_qbit;
   logic [2*WIDTH-1:0] prod_fix;

   div_step #(.WIDTH(WIDTH)) u_div_step (
      .partial_i (div_partial),
      .divisor_i (mb_q),
      .rem_o     (div_rem),
      .q_bit_o   (div_qbit)
   );

   // Divide: acc = {remainder, dividend/quotient}; multiply: acc = {partial sum, product low bits}
   assign div_partial = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
   assign mul_sum     = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (mb_q[0] ? {1'b0, ma_q} : '0);

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      is_div_d  = is_div_q;
      sa_d      = sa_q;
      sb_d      = sb_q;
      ma_d      = ma_q;
      mb_d      = mb_q;
      acc_d     = acc_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      done_d    = 1'b0;
      signed_op = (op == MD_MULT) || (op == MD_DIV);
      abs_a     = (signed_op && a[WIDTH-1]) ? -a : a;
      abs_b     = (signed_op && b[WIDTH-1]) ? -b : b;
      prod_fix  = (sa_q ^ sb_q) ? -acc_q : acc_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               case (op)
                  MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
                     sa_d     = signed_op & a[WIDTH-1];
                     sb_d     = signed_op & b[WIDTH-1];
                     ma_d     = abs_a;
                     mb_d     = abs_b;
                     is_div_d = op[1];
                     acc_d    = op[1] ? {{WIDTH{1'b0}}, abs_a} : '0;
                     cnt_d    = '0;
                     state_d  = S_CALC;
                  end
                  MD_MTHI: hi_d = a;
                  MD_MTLO: lo_d = a;
                  default: ;
               endcase
            end
         end
         S_CALC: begin
            if (is_div_q) begin
               acc_d = {div_rem, acc_q[WIDTH-2:0], div_qbit};
            end else begin
               acc_d = {mul_sum, acc_q[WIDTH-1:1]};
               mb_d  = mb_q >> 1;
            end
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) begin
               state_d = S_FIX;
            end
         end
         S_FIX: begin
            if (is_div_q) begin
               // A zero divisor leaves |a| as remainder; re-signing it restores a
               lo_d = (mb_q == '0) ? '1
                    : ((sa_q ^ sb_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0]);
               hi_d = sa_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
            end else begin
               {hi_d, lo_d} = prod_fix;
            end
            done_d  = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         is_div_q <= 1'b0;
         sa_q     <= 1'b0;
         sb_q     <= 1'b0;
         ma_q     <= '0;
         mb_q     <= '0;
         acc_q    <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         is_div_q <= is_div_d;
         sa_q     <= sa_d;
         sb_q     <= sb_d;
         ma_q     <= ma_d;
         mb_q     <= mb_d;
         acc_q    <= acc_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule
